// File: rtl/code_patch_unit.sv
// Sequential patch unit: runtime-writable patch table in front of a read-only master port.
// One read at a time flows IDLE -> LOOKUP -> (ISSUE -> WAIT ->) RESP; each entry keeps a saturating hit counter.
module code_patch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter int CNT_WIDTH = 8,
  parameter int SUB_REGS_DATA_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH,
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cfg_pat_gen_i,
  input  logic                           cfg_we_i,
  input  logic [IDX_W-1:0]               cfg_idx_i,
  input  logic [ADDR_WIDTH-1:0]          cfg_addr_i,
  input  logic [SUB_REGS_DATA_WIDTH-1:0] cfg_data_i,
  input  logic                           cfg_mode_i,
  input  logic                           cfg_en_i,
  input  logic                           cfg_oneshot_i,
  input  logic                           cfg_nopg_i,
  input  logic                           si_req_i,
  input  logic [ADDR_WIDTH-1:0]          si_addr_i,
  output logic                           si_gnt_o,
  output logic                           si_rvalid_o,
  output logic [DATA_WIDTH-1:0]          si_data_o,
  output logic                           si_nopg_o,
  output logic                           mi_req_o,
  output logic [ADDR_WIDTH-1:0]          mi_addr_o,
  input  logic                           mi_gnt_i,
  input  logic                           mi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]          mi_data_i,
  input  logic [IDX_W-1:0]               cnt_idx_i,
  input  logic                           cnt_clr_i,
  output logic [CNT_WIDTH-1:0]           cnt_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W+1)'(NUM_REGS);

  state_t                         state_r;
  logic [ADDR_WIDTH-1:0]          lat_addr_r;
  logic                           mi_req_r;
  logic [ADDR_WIDTH-1:0]          mi_addr_r;
  logic                           si_rvalid_r;
  logic [DATA_WIDTH-1:0]          si_data_r;
  logic                           si_nopg_r;
  logic [DATA_WIDTH-1:0]          patch_data_r;
  logic                           use_patch_r;

  logic                           ent_en_r      [NUM_REGS];
  logic                           ent_mode_r    [NUM_REGS];
  logic                           ent_oneshot_r [NUM_REGS];
  logic                           ent_nopg_r    [NUM_REGS];
  logic [ADDR_WIDTH-1:0]          ent_addr_r    [NUM_REGS];
  logic [SUB_REGS_DATA_WIDTH-1:0] ent_data_r    [NUM_REGS];
  logic [CNT_WIDTH-1:0]           cnt_r         [NUM_REGS];

  logic                           hit_s;
  logic [IDX_W-1:0]               hit_idx_s;
  logic                           lookup_hit_s;
  logic                           cfg_wr_ok_s;
  logic                           cnt_sel_ok_s;
  logic [CNT_WIDTH-1:0]           cnt_s;

  // Priority match against the latched address; descending scan so the lowest index wins.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = {IDX_W{1'b0}};
    for (int j = NUM_REGS - 1; j >= 0; j--) begin
      if (ent_en_r[j] && (ent_addr_r[j] == lat_addr_r) && cfg_pat_gen_i) begin
        hit_s     = 1'b1;
        hit_idx_s = IDX_W'(j);
      end else begin
        hit_s     = hit_s;
        hit_idx_s = hit_idx_s;
      end
    end
  end

  assign lookup_hit_s = (state_r == LOOKUP) && hit_s;
  assign cfg_wr_ok_s  = cfg_we_i && ({1'b0, cfg_idx_i} < NUM_REGS_W);
  assign cnt_sel_ok_s = ({1'b0, cnt_idx_i} < NUM_REGS_W);

  // Counter read port; out-of-range indices read as zero.
  always_comb begin
    if (cnt_sel_ok_s) begin
      cnt_s = cnt_r[cnt_idx_i];
    end else begin
      cnt_s = {CNT_WIDTH{1'b0}};
    end
  end

  // Patch table: a config write beats the one-shot auto-disable of the same entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < NUM_REGS; j++) begin
        ent_en_r[j]      <= 1'b0;
        ent_mode_r[j]    <= 1'b0;
        ent_oneshot_r[j] <= 1'b0;
        ent_nopg_r[j]    <= 1'b0;
        ent_addr_r[j]    <= {ADDR_WIDTH{1'b0}};
        ent_data_r[j]    <= {SUB_REGS_DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int j = 0; j < NUM_REGS; j++) begin
        if (cfg_wr_ok_s && (cfg_idx_i == IDX_W'(j))) begin
          ent_en_r[j]      <= cfg_en_i;
          ent_mode_r[j]    <= cfg_mode_i;
          ent_oneshot_r[j] <= cfg_oneshot_i;
          ent_nopg_r[j]    <= cfg_nopg_i;
          ent_addr_r[j]    <= cfg_addr_i;
          ent_data_r[j]    <= cfg_data_i;
        end else if (lookup_hit_s && (hit_idx_s == IDX_W'(j)) && ent_oneshot_r[j]) begin
          ent_en_r[j] <= 1'b0;
        end
      end
    end
  end

  // Saturating hit counters; a clear beats a simultaneous increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < NUM_REGS; j++) begin
        cnt_r[j] <= {CNT_WIDTH{1'b0}};
      end
    end else begin
      for (int j = 0; j < NUM_REGS; j++) begin
        if (cnt_clr_i && cnt_sel_ok_s && (cnt_idx_i == IDX_W'(j))) begin
          cnt_r[j] <= {CNT_WIDTH{1'b0}};
        end else if (lookup_hit_s && (hit_idx_s == IDX_W'(j)) &&
                     (cnt_r[j] != {CNT_WIDTH{1'b1}})) begin
          cnt_r[j] <= cnt_r[j] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Transaction FSM with registered handshake and response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= IDLE;
      lat_addr_r   <= {ADDR_WIDTH{1'b0}};
      mi_req_r     <= 1'b0;
      mi_addr_r    <= {ADDR_WIDTH{1'b0}};
      si_rvalid_r  <= 1'b0;
      si_data_r    <= {DATA_WIDTH{1'b0}};
      si_nopg_r    <= 1'b0;
      patch_data_r <= {DATA_WIDTH{1'b0}};
      use_patch_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          si_rvalid_r <= 1'b0;
          if (si_req_i) begin
            lat_addr_r <= si_addr_i;
            state_r    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_s && ent_mode_r[hit_idx_s] && ent_nopg_r[hit_idx_s]) begin
            si_data_r   <= ent_data_r[hit_idx_s][DATA_WIDTH-1:0];
            si_nopg_r   <= 1'b1;
            si_rvalid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            mi_req_r     <= 1'b1;
            mi_addr_r    <= (hit_s && !ent_mode_r[hit_idx_s]) ?
                            ent_data_r[hit_idx_s][ADDR_WIDTH-1:0] : lat_addr_r;
            use_patch_r  <= hit_s && ent_mode_r[hit_idx_s];
            patch_data_r <= ent_data_r[hit_idx_s][DATA_WIDTH-1:0];
            si_nopg_r    <= 1'b0;
            state_r      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mi_gnt_i) begin
            mi_req_r <= 1'b0;
            state_r  <= WAIT;
          end
        end
        WAIT: begin
          if (mi_rvalid_i) begin
            si_data_r   <= use_patch_r ? patch_data_r : mi_data_i;
            si_rvalid_r <= 1'b1;
            state_r     <= RESP;
          end
        end
        RESP: begin
          si_rvalid_r <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          mi_req_r    <= 1'b0;
          si_rvalid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign si_gnt_o    = (state_r == IDLE);
  assign si_rvalid_o = si_rvalid_r;
  assign si_data_o   = si_data_r;
  assign si_nopg_o   = si_nopg_r;
  assign mi_req_o    = mi_req_r;
  assign mi_addr_o   = mi_addr_r;
  assign cnt_o       = cnt_s;

endmodule

// File: tb/tb_code_patch_unit.sv
// Directed bench for code_patch_unit (CNT_WIDTH=2 so saturation is reachable quickly).
module tb_code_patch_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cfg_pat_gen_i, cfg_we_i, cfg_mode_i, cfg_en_i, cfg_oneshot_i, cfg_nopg_i;
  logic [2:0]  cfg_idx_i, cnt_idx_i;
  logic [31:0] cfg_addr_i, cfg_data_i, si_addr_i, si_data_o, mi_addr_o, mi_data_i;
  logic        si_req_i, si_gnt_o, si_rvalid_o, si_nopg_o, mi_req_o, mi_gnt_i, mi_rvalid_i;
  logic        cnt_clr_i;
  logic [1:0]  cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  code_patch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .CNT_WIDTH(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cfg_pat_gen_i(cfg_pat_gen_i), .cfg_we_i(cfg_we_i),
    .cfg_idx_i(cfg_idx_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .cfg_mode_i(cfg_mode_i), .cfg_en_i(cfg_en_i), .cfg_oneshot_i(cfg_oneshot_i),
    .cfg_nopg_i(cfg_nopg_i), .si_req_i(si_req_i), .si_addr_i(si_addr_i),
    .si_gnt_o(si_gnt_o), .si_rvalid_o(si_rvalid_o), .si_data_o(si_data_o),
    .si_nopg_o(si_nopg_o), .mi_req_o(mi_req_o), .mi_addr_o(mi_addr_o),
    .mi_gnt_i(mi_gnt_i), .mi_rvalid_i(mi_rvalid_i), .mi_data_i(mi_data_i),
    .cnt_idx_i(cnt_idx_i), .cnt_clr_i(cnt_clr_i), .cnt_o(cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [2:0] idx, input logic [1:0] exp);
    cnt_idx_i = idx;
    #1;
    chk(tag, 32'(cnt_o), 32'(exp));
  endtask

  task automatic cfg_set(input logic [2:0] idx, input logic [31:0] addr, input logic [31:0] data,
                         input logic mode, input logic en, input logic os, input logic np);
    cfg_idx_i = idx; cfg_addr_i = addr; cfg_data_i = data;
    cfg_mode_i = mode; cfg_en_i = en; cfg_oneshot_i = os; cfg_nopg_i = np;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [31:0] addr, input logic [31:0] data,
                           input logic mode, input logic en, input logic os, input logic np);
    cfg_set(idx, addr, data, mode, en, os, np);
    cfg_we_i = 1'b1;
    tick();
    cfg_we_i = 1'b0;
  endtask

  // One read with gnt in cycle 2 and rvalid in cycle 3 when propagated; cycle 1 is LOOKUP,
  // where an optional counter clear or config write (using current cfg_* values) is pulsed.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic prop,
                         input logic [31:0] mdata, input logic [31:0] exp_maddr,
                         input logic [31:0] exp_data, input logic exp_nopg,
                         input logic clr_at_lookup, input logic wr_at_lookup);
    chk({tag, ".gnt0"}, 32'(si_gnt_o), 32'h1);
    si_req_i = 1'b1; si_addr_i = addr;
    tick();
    si_req_i = 1'b0; si_addr_i = 32'h0;
    cnt_clr_i = clr_at_lookup; cfg_we_i = wr_at_lookup;
    chk({tag, ".gnt1"}, 32'(si_gnt_o), 32'h0);
    chk({tag, ".req1"}, 32'(mi_req_o), 32'h0);
    tick();
    cnt_clr_i = 1'b0; cfg_we_i = 1'b0;
    if (prop) begin
      chk({tag, ".req2"}, 32'(mi_req_o), 32'h1);
      chk({tag, ".maddr"}, mi_addr_o, exp_maddr);
      chk({tag, ".rv2"}, 32'(si_rvalid_o), 32'h0);
      mi_gnt_i = 1'b1;
      tick();
      mi_gnt_i = 1'b0;
      chk({tag, ".req3"}, 32'(mi_req_o), 32'h0);
      mi_rvalid_i = 1'b1; mi_data_i = mdata;
      tick();
      mi_rvalid_i = 1'b0; mi_data_i = 32'h0;
      chk({tag, ".rv4"}, 32'(si_rvalid_o), 32'h1);
    end else begin
      chk({tag, ".rv2"}, 32'(si_rvalid_o), 32'h1);
      chk({tag, ".noreq"}, 32'(mi_req_o), 32'h0);
    end
    chk({tag, ".data"}, si_data_o, exp_data);
    chk({tag, ".nopg"}, 32'(si_nopg_o), 32'(exp_nopg));
    tick();
    chk({tag, ".rvoff"}, 32'(si_rvalid_o), 32'h0);
    chk({tag, ".gntend"}, 32'(si_gnt_o), 32'h1);
  endtask

  initial begin
    rst_ni = 1'b0;
    cfg_pat_gen_i = 1'b1; cfg_we_i = 1'b0; cnt_clr_i = 1'b0; cnt_idx_i = 3'd0;
    cfg_set(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    si_req_i = 1'b1; si_addr_i = 32'h100;
    mi_gnt_i = 1'b0; mi_rvalid_i = 1'b0; mi_data_i = 32'h0;

    // Reset state, with a request pending throughout reset.
    repeat (3) tick();
    chk("rst.gnt", 32'(si_gnt_o), 32'h1);
    chk("rst.rvalid", 32'(si_rvalid_o), 32'h0);
    chk("rst.data", si_data_o, 32'h0);
    chk("rst.nopg", 32'(si_nopg_o), 32'h0);
    chk("rst.mreq", 32'(mi_req_o), 32'h0);
    chk("rst.maddr", mi_addr_o, 32'h0);
    si_req_i = 1'b0;
    rst_ni = 1'b1;
    tick(); tick();
    chk("rst.noaccept.req", 32'(mi_req_o), 32'h0);
    chk("rst.noaccept.gnt", 32'(si_gnt_o), 32'h1);

    // Miss with an empty table.
    do_read("miss", 32'h100, 1'b1, 32'hAAAA, 32'h100, 32'hAAAA, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) chk_cnt("miss.cnt", 3'(i), 2'd0);

    // Address patch, lowest index wins.
    cfg_write(3'd2, 32'h200, 32'h800, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg_write(3'd5, 32'h200, 32'h880, 1'b0, 1'b1, 1'b0, 1'b0);
    do_read("prio", 32'h200, 1'b1, 32'h1111, 32'h800, 32'h1111, 1'b0, 1'b0, 1'b0);
    chk_cnt("prio.cnt2", 3'd2, 2'd1);
    chk_cnt("prio.cnt5", 3'd5, 2'd0);

    // Data patch without master access.
    cfg_write(3'd0, 32'h300, 32'hDEAD, 1'b1, 1'b1, 1'b0, 1'b1);
    do_read("nopg", 32'h300, 1'b0, 32'h0, 32'h0, 32'hDEAD, 1'b1, 1'b0, 1'b0);
    chk_cnt("nopg.cnt0", 3'd0, 2'd1);

    // Data patch with propagation: master data is replaced.
    cfg_write(3'd4, 32'h340, 32'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0);
    do_read("dpg", 32'h340, 1'b1, 32'h5555, 32'h340, 32'hBEEF, 1'b0, 1'b0, 1'b0);

    // One-shot entry auto-disables after its first hit.
    cfg_write(3'd1, 32'h500, 32'h900, 1'b0, 1'b1, 1'b1, 1'b0);
    do_read("os1", 32'h500, 1'b1, 32'h1, 32'h900, 32'h1, 1'b0, 1'b0, 1'b0);
    do_read("os2", 32'h500, 1'b1, 32'h2, 32'h500, 32'h2, 1'b0, 1'b0, 1'b0);
    chk_cnt("os.cnt1", 3'd1, 2'd1);

    // Config write colliding with the one-shot clear keeps the entry enabled.
    cfg_write(3'd6, 32'h600, 32'h980, 1'b0, 1'b1, 1'b1, 1'b0);
    do_read("col1", 32'h600, 1'b1, 32'h3, 32'h980, 32'h3, 1'b0, 1'b0, 1'b1);
    do_read("col2", 32'h600, 1'b1, 32'h4, 32'h980, 32'h4, 1'b0, 1'b0, 1'b0);
    do_read("col3", 32'h600, 1'b1, 32'h5, 32'h600, 32'h5, 1'b0, 1'b0, 1'b0);
    chk_cnt("col.cnt6", 3'd6, 2'd2);

    // Global enable low suppresses matching.
    cfg_pat_gen_i = 1'b0;
    do_read("patgen", 32'h200, 1'b1, 32'h6, 32'h200, 32'h6, 1'b0, 1'b0, 1'b0);
    chk_cnt("patgen.cnt2", 3'd2, 2'd1);
    cfg_pat_gen_i = 1'b1;

    // Counter saturation, then clear colliding with a hit.
    cfg_write(3'd3, 32'h400, 32'h404, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_read("sat", 32'h400, 1'b1, 32'h7, 32'h404, 32'h7, 1'b0, 1'b0, 1'b0);
    chk_cnt("sat.cnt3a", 3'd3, 2'd3);
    for (int i = 0; i < 2; i++) do_read("sat", 32'h400, 1'b1, 32'h8, 32'h404, 32'h8, 1'b0, 1'b0, 1'b0);
    chk_cnt("sat.cnt3b", 3'd3, 2'd3);
    cnt_idx_i = 3'd3;
    do_read("clrhit", 32'h400, 1'b1, 32'h9, 32'h404, 32'h9, 1'b0, 1'b1, 1'b0);
    chk_cnt("clrhit.cnt3", 3'd3, 2'd0);
    do_read("afterclr", 32'h400, 1'b1, 32'hA, 32'h404, 32'hA, 1'b0, 1'b0, 1'b0);
    chk_cnt("afterclr.cnt3", 3'd3, 2'd1);

    // Reset while in WAIT.
    si_req_i = 1'b1; si_addr_i = 32'h700;
    tick();
    si_req_i = 1'b0;
    tick();
    chk("rstw.req2", 32'(mi_req_o), 32'h1);
    mi_gnt_i = 1'b1;
    tick();
    mi_gnt_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rstw.mreq", 32'(mi_req_o), 32'h0);
    chk("rstw.rvalid", 32'(si_rvalid_o), 32'h0);
    chk("rstw.gnt", 32'(si_gnt_o), 32'h1);
    tick(); tick();
    rst_ni = 1'b1;
    mi_rvalid_i = 1'b1; mi_data_i = 32'h7777;
    tick();
    mi_rvalid_i = 1'b0; mi_data_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("rstw.late.rvalid", 32'(si_rvalid_o), 32'h0);
      chk("rstw.late.data", si_data_o, 32'h0);
      tick();
    end
    chk_cnt("rstw.cnt3", 3'd3, 2'd0);
    do_read("post", 32'h200, 1'b1, 32'hB, 32'h200, 32'hB, 1'b0, 1'b0, 1'b0);
    chk_cnt("post.cnt2", 3'd2, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/code_patch_unit.md
# code_patch_unit

Sequential, parametrised successor to the combinational patch core. It sits between the CPU-side slave read port and the memory-side master port. It owns an internal, runtime-writable table of NUM_REGS patch entries, and it runs one read transaction at a time through a registered lookup and handshake FSM. Each entry has a per-entry address/data mode, an optional one-shot auto-disable, and a saturating hit counter readable by firmware.

## Interface
Parameters:
- ADDR_WIDTH, 32, slave/master address width
- DATA_WIDTH, 32, read data width
- NUM_REGS, 8, patch entries (≥1); IDX_W = max(1, $clog2(NUM_REGS))
- CNT_WIDTH, 8, per-entry hit counter width
- SUB_REGS_DATA_WIDTH, max(ADDR_WIDTH, DATA_WIDTH), entry payload width

Ports (one clock, clk_i; reset rst_ni is asynchronous, active-low):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- cfg_pat_gen_i  in  1  global patch enable
- cfg_we_i  in  1  entry write strobe
- cfg_idx_i  in  IDX_W  entry index to write
- cfg_addr_i  in  ADDR_WIDTH  match address
- cfg_data_i  in  SUB_REGS_DATA_WIDTH  substitute address or data
- cfg_mode_i  in  1  0 = address patch, 1 = data patch
- cfg_en_i / cfg_oneshot_i / cfg_nopg_i  in  1 each  entry enable / auto-disable after hit / suppress propagation
- si_req_i  in  1  slave read request
- si_addr_i  in  ADDR_WIDTH  slave read address
- si_gnt_o  out  1  request accepted
- si_rvalid_o  out  1  response valid, 1-cycle pulse
- si_data_o  out  DATA_WIDTH  response data
- si_nopg_o  out  1  response was patched without a master access
- mi_req_o  out  1  master read request
- mi_addr_o  out  ADDR_WIDTH  master address
- mi_gnt_i  in  1  master accept
- mi_rvalid_i  in  1  master response valid
- mi_data_i  in  DATA_WIDTH  master response data
- cnt_idx_i  in  IDX_W  counter read/clear index
- cnt_clr_i  in  1  clear counter cnt_idx_i
- cnt_o  out  CNT_WIDTH  combinational read of counter cnt_idx_i

## Operation
- FSM states: IDLE, LOOKUP, ISSUE, WAIT, RESP.
- si_gnt_o = (state == IDLE). Accept occurs when si_req_i & si_gnt_o; si_addr_i is latched and the FSM goes to LOOKUP.
- LOOKUP: entry j matches when en[j] & (addr[j] == latched addr) & cfg_pat_gen_i. The lowest matching index wins. The result (hit, idx) is registered.
  - No hit, or address-mode hit: mi_addr = latched addr, or data[idx][ADDR_WIDTH-1:0] on a hit. Next state ISSUE.
  - Data-mode hit with nopg: si_data = data[idx][DATA_WIDTH-1:0], nopg flag = 1. Next state RESP.
  - Data-mode hit without nopg: patch data is held. Next state ISSUE. mi_data_i is discarded and replaced by the patch data at RESP.
- ISSUE: mi_req_o = 1 and mi_addr_o is stable until mi_gnt_i; then go to WAIT.
- WAIT: on mi_rvalid_i, capture the data (mi_data_i or held patch data) into si_data_o and go to RESP.
- RESP: si_rvalid_o = 1 for one cycle with si_nopg_o valid; then go to IDLE. si_data_o holds its value until the next RESP.
- On a hit in LOOKUP: cnt[idx] increments, saturating at 2^CNT_WIDTH−1. If oneshot[idx], en[idx] is cleared at the end of LOOKUP.
- Config write updates all fields of entry cfg_idx_i at the clock edge. A lookup sees it from the next cycle onward.
- cfg_idx_i ≥ NUM_REGS: write ignored. cnt_idx_i ≥ NUM_REGS: cnt_o = 0, clear ignored.

## Timing
- Reset: state IDLE, all entries zero (en=0), counters 0. Outputs: si_gnt_o=1, si_rvalid_o=0, si_data_o=0, si_nopg_o=0, mi_req_o=0, mi_addr_o=0.
- Requests present while rst_ni is low are not accepted.
- Latency, data-nopg hit: accept at cycle 0, si_rvalid_o at cycle 2.
- Latency, propagated access: accept at 0, mi_req_o at 2. With gnt at 2 and rvalid at 3, si_rvalid_o is at 4.
- mi_rvalid_i is only sampled in WAIT. rvalid in the same cycle as gnt is not allowed.
- One transaction is outstanding at a time. si_gnt_o is low from LOOKUP through RESP.
- Same-cycle collisions:
  - Config write to the entry being one-shot-cleared: the write wins.
  - cnt_clr_i together with an increment of the same counter: the clear wins (result 0).
- Reset mid-transaction: immediate return to IDLE. mi_req_o drops and no si_rvalid_o is produced. A late mi_rvalid_i is ignored.
- cfg_pat_gen_i is sampled only in LOOKUP.

## Test plan
- Miss: write no entries; read 0x100 with mi_data_i=0xAAAA, gnt at 2, rvalid at 3 -> mi_addr_o=0x100, si_data_o=0xAAAA at cycle 4, si_nopg_o=0, all cnt=0.
- Address patch + priority: entries 2 and 5 both match 0x200, entry 2 data=0x800 -> mi_addr_o=0x800, cnt[2]=1, cnt[5]=0.
- Data patch nopg: entry 0 {0x300, 0xDEAD, mode=1, nopg=1} -> si_rvalid_o at cycle 2 with 0xDEAD and si_nopg_o=1; mi_req_o never asserted.
- One-shot: entry 1 one-shot address patch; two reads of its address -> first read patched, second goes to the original address; en[1]=0.
- Counter saturation/clear: CNT_WIDTH=2, 5 hits -> cnt_o=3; cnt_clr_i in the same cycle as a hit -> 0.
- Reset while in WAIT: mi_req_o=0, no si_rvalid_o, later mi_rvalid_i ignored, next read completes normally.
